inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Instruction memory for the pipelined RISC-V core: the responder side of the core's instruction-fetch port (`rom_ce`/`rom_addr` in, `rom_inst` out, same-cycle read). It is filled at run time through a byte-stream load port with a valid/ready handshake. Bytes are assembled little-endian into 32-bit words. While a load is in progress, `cpu_hold` holds the core in reset; the core is released only after the final byte is accepted.

## Interface
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (DEPTH = 2^ADDR_WIDTH = 1024)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rom_ce  in  1  fetch enable from core
- rom_addr  in  32  byte address from core (`InstAddrBus`)
- rom_inst  out  32  fetched instruction (`InstBus`), combinational
- ld_start  in  1  single-cycle pulse that begins or restarts a load
- ld_valid  in  1  load byte valid
- ld_data  in  8  load byte
- ld_last  in  1  qualifies ld_data as the final byte of the image
- ld_ready  out  1  byte accepted when ld_valid && ld_ready
- cpu_hold  out  1  drive into core reset (OR with rst at top level)
- ld_words  out  ADDR_WIDTH+1  words written in current/last load
- ld_err  out  1  sticky error for current/last load

## Operation
- State machine: IDLE, LOAD, RUN.
- Reset: state=IDLE, cpu_hold=1, ld_words=0, ld_err=0, byte index=0, pack register=0. Memory contents are not cleared.
- ld_ready = (state==LOAD).
- IDLE: ld_start → LOAD. Clear ld_words, ld_err, byte index.
- LOAD, byte accepted:
  - Byte goes to lane [8*idx+7:8*idx]; idx increments mod 4.
  - On idx==3, write the assembled word to mem[ld_words] and increment ld_words.
- LOAD, ld_last accepted:
  - idx==3: normal word write, → RUN.
  - Otherwise: write the partial word with unfilled upper lanes zeroed, increment ld_words, set ld_err, → RUN.
- Overflow: a word write with ld_words==DEPTH is discarded and sets ld_err. ld_words saturates at DEPTH. Loading continues until ld_last.
- ld_start in LOAD: restart. Pointer, index and err are cleared; memory already written is kept. ld_start has priority over a byte accepted in the same cycle; that byte is dropped.
- RUN: cpu_hold=0. ld_start → LOAD (reload) and cpu_hold=1.
- Read path, combinational:
  - rom_inst = 0 when rom_ce=0.
  - rom_inst = 0 when rom_addr[31:ADDR_WIDTH+2]≠0 (out of range).
  - Otherwise rom_inst = mem[rom_addr[ADDR_WIDTH+1:2]]. rom_addr[1:0] is ignored.
- Reads are served in every state.

## Timing
- Fetch latency: 0 cycles. rom_inst is valid in the same cycle as rom_addr.
- A word write on edge N is visible on rom_inst from cycle N+1. A same-cycle read of the word being written returns the old contents.
- cpu_hold is registered:
  - Deasserts in the cycle after the edge that accepts the ld_last byte.
  - Asserts in the cycle after the edge that samples ld_start in RUN.
- ld_ready rises the cycle after ld_start is sampled in IDLE or RUN.
- ld_words and ld_err update on the accepting edge.
- Async rst mid-load: immediate return to IDLE. Partially loaded memory is left as-is; the in-flight pack register is lost.

## Structure
- Shared defines (defines.v): `InstAddrBus`, `InstBus`, and the state encodings (`LdIdle`, `LdLoad`, `LdRun`). ADDR_WIDTH stays a module parameter.
- One sub-module is natural: `byte_word_packer`.
  - Owns the byte index and the 32-bit pack register.
  - Inputs: byte strobe, last, clear.
  - Outputs: word-ready pulse, packed word, partial flag.
- Top level holds the FSM, write pointer, error flag, memory array and read mux.

## Test plan
- Reset, then ld_start; stream 8 bytes 13,05,10,00,93,05,20,00 with last on the 8th → mem[0]=0x00100513, mem[1]=0x00200593, ld_words=2, ld_err=0, cpu_hold falls the cycle after the last byte. With rom_ce=1, rom_addr=4 → rom_inst=0x00200593. rom_ce=0 → 0.
- Load 6 bytes AA,BB,CC,DD,11,22 with last on 22 → mem[1]=0x00002211, ld_words=2, ld_err=1, state RUN.
- ADDR_WIDTH=2, load 20 bytes → ld_words=4, ld_err=1, mem[0..3] hold the first 16 bytes; rom_addr=0x10 → rom_inst=0.
- Assert ld_start mid-load after 5 bytes, then load 4 bytes → ld_words=1, ld_err=0, mem[0] holds the new word.
- Assert rst after 3 bytes accepted → cpu_hold=1, ld_ready=0, ld_words=0 immediately; earlier complete words unchanged.
- In RUN, ld_start together with ld_valid → cpu_hold=1 the next cycle, no byte accepted, ld_ready=1 the next cycle.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared types for the instruction ROM loader: bus widths, loader states and a
// byte-lane insert helper used by the packer.
package inst_rom_loader_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

  function automatic inst_t lane_put(input inst_t w, input logic [1:0] idx,
                                     input logic [7:0] b);
    inst_t r;
    r = w;
    r[8*idx +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/inst_rom_loader_byte_word_packer.sv
// Assembles a little-endian byte stream into 32-bit words; a word is emitted on
// the fourth byte or early on the final byte with unfilled upper lanes zero.
module byte_word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_stb,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       clear,
  output logic       word_vld,
  output inst_t      word,
  output logic       partial
);
  logic [1:0] idx_q, idx_d;
  inst_t      pack_q, pack_d;

  always_comb begin
    word     = lane_put(pack_q, idx_q, byte_data);
    word_vld = byte_stb && ((idx_q == 2'd3) || byte_last);
    partial  = word_vld && (idx_q != 2'd3);
    idx_d    = idx_q;
    pack_d   = pack_q;
    if (clear) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (byte_stb) begin
      // pack register is zeroed after every word so a short tail reads as zero
      if (word_vld) begin
        idx_d  = '0;
        pack_d = '0;
      end else begin
        idx_d  = idx_q + 2'd1;
        pack_d = word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      pack_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pack_q <= pack_d;
    end
  end
endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory for the core's fetch port, filled at run time from a byte
// stream; holds the core in reset until a complete image has been streamed in.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_ce,
  input  inst_addr_t          rom_addr,
  output inst_t               rom_inst,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [7:0]          ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                cpu_hold,
  output logic [ADDR_WIDTH:0] ld_words,
  output logic                ld_err
);
  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  ld_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0] words_q, words_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;
  logic                we;
  logic                acc;
  logic                pk_vld, pk_partial;
  inst_t               pk_word;
  inst_t               mem_q [DEPTH];

  // a restart pulse wins over a byte offered in the same cycle
  assign acc = (state_q == LD_LOAD) && ld_valid && !ld_start;

  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_stb  (acc),
    .byte_data (ld_data),
    .byte_last (ld_last),
    .clear     (ld_start),
    .word_vld  (pk_vld),
    .word      (pk_word),
    .partial   (pk_partial)
  );

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    err_d   = err_q;
    hold_d  = hold_q;
    we      = 1'b0;
    case (state_q)
      LD_IDLE, LD_RUN: begin
        if (ld_start) begin
          state_d = LD_LOAD;
          words_d = '0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      LD_LOAD: begin
        if (ld_start) begin
          words_d = '0;
          err_d   = 1'b0;
        end else if (acc) begin
          if (pk_vld) begin
            if (words_q == DEPTH_W) begin
              err_d = 1'b1;
            end else begin
              we      = 1'b1;
              words_d = words_q + (ADDR_WIDTH+1)'(1);
            end
          end
          if (pk_partial) err_d = 1'b1;
          if (ld_last) begin
            state_d = LD_RUN;
            hold_d  = 1'b0;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LD_IDLE;
      words_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  // contents survive reset so a partially loaded image stays visible
  always_ff @(posedge clk) begin
    if (we) mem_q[words_q[ADDR_WIDTH-1:0]] <= pk_word;
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^rom_addr[1:0];

  always_comb begin
    rom_inst = '0;
    if (rom_ce && (rom_addr[INST_ADDR_W-1:ADDR_WIDTH+2] == '0))
      rom_inst = mem_q[rom_addr[ADDR_WIDTH+1:2]];
  end

  assign ld_ready = (state_q == LD_LOAD);
  assign cpu_hold = hold_q;
  assign ld_words = words_q;
  assign ld_err   = err_q;
endmodule

// File: tb/tb_inst_rom_loader.sv
// Drives a 1024-word and a 4-word loader with identical stimulus and checks both
// against a byte-count model every cycle, plus literal expectations.
module tb_inst_rom_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = '0;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_data = '0;

  logic [31:0] b_inst, s_inst;
  logic        b_ready, s_ready, b_hold, s_hold, b_err, s_err;
  logic [10:0] b_words;
  logic [2:0]  s_words;

  inst_rom_loader #(.ADDR_WIDTH(10)) dut_b (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(b_inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(b_ready), .cpu_hold(b_hold), .ld_words(b_words), .ld_err(b_err));

  inst_rom_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(s_inst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(s_ready), .cpu_hold(s_hold), .ld_words(s_words), .ld_err(s_err));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: everything derives from bytes accepted this load
  int          m_st = 0;        // 0 idle, 1 load, 2 run
  int          m_n = 0;
  bit          m_ended = 0;
  logic [7:0]  m_pb [4];
  logic [31:0] mb [1024];
  bit          kb [1024];
  logic [31:0] ms [4];
  bit          ks [4];

  function automatic int word_events();
    return m_ended ? (m_n + 3) / 4 : m_n / 4;
  endfunction
  function automatic int exp_words(input int d);
    int ev = word_events();
    return (ev > d) ? d : ev;
  endfunction
  function automatic bit exp_err(input int d);
    return (word_events() > d) || (m_ended && (m_n % 4 != 0));
  endfunction

  task automatic model_step();
    int lane, w;
    logic [31:0] word;
    if (rst) begin
      m_st = 0; m_n = 0; m_ended = 0;
    end else if (ld_start) begin
      m_st = 1; m_n = 0; m_ended = 0;
    end else if (m_st == 1 && ld_valid) begin
      lane = m_n % 4;
      m_pb[lane] = ld_data;
      m_n++;
      if (lane == 3 || ld_last) begin
        word = 0;
        for (int k = 0; k <= lane; k++) word = word | (32'(m_pb[k]) << (8 * k));
        w = (m_n - 1) / 4;
        if (w < 1024) begin mb[w] = word; kb[w] = 1; end
        if (w < 4)    begin ms[w] = word; ks[w] = 1; end
      end
      if (ld_last) begin m_st = 2; m_ended = 1; end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  always @(negedge clk) begin
    chk("ready_b", 32'(b_ready), 32'(m_st == 1));
    chk("ready_s", 32'(s_ready), 32'(m_st == 1));
    chk("hold_b", 32'(b_hold), 32'(m_st != 2));
    chk("hold_s", 32'(s_hold), 32'(m_st != 2));
    chk("words_b", 32'(b_words), 32'(exp_words(1024)));
    chk("words_s", 32'(s_words), 32'(exp_words(4)));
    chk("err_b", 32'(b_err), 32'(exp_err(1024)));
    chk("err_s", 32'(s_err), 32'(exp_err(4)));
    if (!rom_ce || (rom_addr >> 12) != 0) chk("inst_b", b_inst, 32'h0);
    else if (kb[rom_addr[11:2]]) chk("inst_b", b_inst, mb[rom_addr[11:2]]);
    if (!rom_ce || (rom_addr >> 4) != 0) chk("inst_s", s_inst, 32'h0);
    else if (ks[rom_addr[3:2]]) chk("inst_s", s_inst, ms[rom_addr[3:2]]);
  end

  // ---------------- stimulus
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int t = 0;
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    while (!b_ready && t < 8) begin step(); t++; end
    if (t == 8) begin n_cmp++; n_bad++; $display("FAIL ready_timeout: got 0 expected 1"); end
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic start();
    ld_start = 1'b1; step(); ld_start = 1'b0;
  endtask

  task automatic peek_b(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rom_addr = a; #1; chk(nm, b_inst, exp);
  endtask

  logic [7:0] img1 [8];

  initial begin
    img1 = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    step(); step();
    chk("rst_hold", 32'(b_hold), 32'h1);
    chk("rst_words", 32'(b_words), 32'h0);
    chk("rst_ready", 32'(b_ready), 32'h0);
    rst = 1'b0;
    step();

    // basic image
    start();
    chk("ready_after_start", 32'(b_ready), 32'h1);
    for (int i = 0; i < 7; i++) send(img1[i], 1'b0);
    chk("hold_before_last", 32'(b_hold), 32'h1);
    send(img1[7], 1'b1);
    chk("hold_after_last", 32'(b_hold), 32'h0);
    chk("img1_words", 32'(b_words), 32'd2);
    chk("img1_err", 32'(b_err), 32'h0);
    rom_ce = 1'b1;
    peek_b("img1_w1", 32'h4, 32'h00200593);
    peek_b("img1_w0", 32'h0, 32'h00100513);
    rom_ce = 1'b0; #1;
    chk("ce_low", b_inst, 32'h0);
    rom_ce = 1'b1;
    step();

    // short tail
    start();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 1);
    chk("tail_words", 32'(b_words), 32'd2);
    chk("tail_err", 32'(b_err), 32'h1);
    chk("tail_ready", 32'(b_ready), 32'h0);
    peek_b("tail_w1", 32'h4, 32'h00002211);
    peek_b("tail_w0", 32'h0, 32'hDDCCBBAA);
    step();

    // overflow of the 4-word instance
    start();
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i), i == 19);
    chk("ovf_words_s", 32'(s_words), 32'd4);
    chk("ovf_err_s", 32'(s_err), 32'h1);
    chk("ovf_words_b", 32'(b_words), 32'd5);
    rom_addr = 32'h10; #1;
    chk("ovf_oob_s", s_inst, 32'h0);
    rom_addr = 32'hC; #1;
    chk("ovf_w3_s", s_inst, 32'h4F4E4D4C);
    step();

    // restart mid-load
    start();
    for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b0);
    start();
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), i == 3);
    chk("restart_words", 32'(b_words), 32'd1);
    chk("restart_err", 32'(b_err), 32'h0);
    peek_b("restart_w0", 32'h0, 32'hA3A2A1A0);
    peek_b("restart_w1_kept", 32'h4, 32'h47464544);
    step();

    // async reset mid-load
    start();
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) send(8'(8'hD0 + i), 1'b0);
    rst = 1'b1; #1;
    chk("arst_hold", 32'(b_hold), 32'h1);
    chk("arst_ready", 32'(b_ready), 32'h0);
    chk("arst_words", 32'(b_words), 32'h0);
    peek_b("arst_w0_kept", 32'h0, 32'hC3C2C1C0);
    step();
    rst = 1'b0;
    step();

    // reload from RUN with a byte offered alongside ld_start
    start();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
    step();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("reload_hold", 32'(b_hold), 32'h1);
    chk("reload_ready", 32'(b_ready), 32'h1);
    chk("reload_words", 32'(b_words), 32'h0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    peek_b("reload_w0", 32'h0, 32'h04030201);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
